// File: rtl/imem_boot_loader_pkg.sv
// Shared types and SRAM pin constants for the imem boot loader.
// Build option IMEM_BOOT_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to the stream.
package imem_boot_loader_pkg;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned LANES = 4;

  // SRAM control levels (all active-low)
  localparam logic       CEN_OFF  = 1'b1;
  localparam logic       GWEN_RD  = 1'b1;
  localparam logic [7:0] WEN_NONE = 8'hFF;
  localparam logic [7:0] WEN_ALL  = 8'h00;

  typedef enum logic [2:0] {
    StSample,
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StRun,
    StErr
  } state_e;

endpackage

// File: rtl/imem_port_mux.sv
// One SRAM lane: selects loader-driven pins during boot, core imem request pins once running.
module imem_port_mux #(
  parameter int unsigned AW = 9
) (
  input  logic          core_sel,
  input  logic          l_cen,
  input  logic          l_gwen,
  input  logic [7:0]    l_wen,
  input  logic [AW-1:0] l_a,
  input  logic [7:0]    l_d,
  input  logic          c_cen,
  input  logic          c_gwen,
  input  logic [7:0]    c_wen,
  input  logic [AW-1:0] c_a,
  input  logic [7:0]    c_d,
  output logic          cen,
  output logic          gwen,
  output logic [7:0]    wen,
  output logic [AW-1:0] a,
  output logic [7:0]    d
);

  always_comb begin
    if (core_sel) begin
      cen  = c_cen;
      gwen = c_gwen;
      wen  = c_wen;
      a    = c_a;
      d    = c_d;
    end else begin
      cen  = l_cen;
      gwen = l_gwen;
      wen  = l_wen;
      a    = l_a;
      d    = l_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed image into the four imem byte lanes, then hands the
// SRAMs to the core and releases core_rst. IMEM_BOOT_LOADER_CHECKSUM_EN enables the XOR check.
module imem_boot_loader #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned LANES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_sel,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          core_rst,
  output logic          busy,
  output logic          error,
  output logic [AW:0]   words_loaded,
  input  logic          c_CEN  [0:LANES-1],
  input  logic          c_GWEN [0:LANES-1],
  input  logic [7:0]    c_WEN  [0:LANES-1],
  input  logic [AW-1:0] c_A    [0:LANES-1],
  input  logic [7:0]    c_D    [0:LANES-1],
  output logic          CEN    [0:LANES-1],
  output logic          GWEN   [0:LANES-1],
  output logic [7:0]    WEN    [0:LANES-1],
  output logic [AW-1:0] A      [0:LANES-1],
  output logic [7:0]    D      [0:LANES-1]
);
  import imem_boot_loader_pkg::*;

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LastLane = LW'(LANES - 1);

  state_e        state_q, state_d;
  logic          fin_q, fin_d;
  logic [7:0]    len_lo_q;
  logic [AW:0]   n_q;
  logic [AW-1:0] word_q;
  logic [LW-1:0] lane_q;
  logic [AW:0]   words_q;
  logic          rx_ready_q, busy_q, error_q, core_rst_q;
  logic          l_cen_q  [0:LANES-1];
  logic          l_gwen_q [0:LANES-1];
  logic [7:0]    l_wen_q  [0:LANES-1];
  logic [AW-1:0] l_a_q    [0:LANES-1];
  logic [7:0]    l_d_q    [0:LANES-1];
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]    xor_q;
`endif

  logic        accept, last_byte, run_sel;
  logic [15:0] len_n;

  assign accept    = rx_valid & rx_ready_q;
  assign len_n     = {rx_data, len_lo_q};
  assign last_byte = ({1'b0, word_q} == (n_q - (AW+1)'(1))) && (lane_q == LastLane);
  assign run_sel   = (state_q == StRun);

  assign rx_ready     = rx_ready_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign core_rst     = core_rst_q;
  assign words_loaded = words_q;

  always_comb begin
    state_d = state_q;
    fin_d   = 1'b0;
    unique case (state_q)
      StSample: state_d = boot_sel ? StLenLo : StRun;
      StLenLo:  if (accept) state_d = StLenHi;
      StLenHi: begin
        if (accept) state_d = (len_n == '0 || len_n > 16'(DEPTH)) ? StErr : StData;
      end
      StData: begin
        if (fin_q) begin
          state_d = StRun;
        end else if (accept && last_byte) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          // Hold one cycle so the final write pulse reaches the SRAM before the core owns it
          fin_d = 1'b1;
`endif
        end
      end
      StChk: begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        if (accept) state_d = (rx_data == xor_q) ? StRun : StErr;
`else
        state_d = StErr;
`endif
      end
      StRun:   ;
      StErr:   ;
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSample;
      fin_q      <= 1'b0;
      len_lo_q   <= '0;
      n_q        <= '0;
      word_q     <= '0;
      lane_q     <= '0;
      words_q    <= '0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      error_q    <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
      for (int i = 0; i < LANES; i++) begin
        l_cen_q[i]  <= CEN_OFF;
        l_gwen_q[i] <= GWEN_RD;
        l_wen_q[i]  <= WEN_NONE;
        l_a_q[i]    <= '0;
        l_d_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fin_q      <= fin_d;
      rx_ready_q <= (state_d inside {StLenLo, StLenHi, StChk}) ||
                    (state_d == StData && !fin_d);
      busy_q     <= state_d inside {StSample, StLenLo, StLenHi, StData, StChk};
      error_q    <= (state_d == StErr);
      core_rst_q <= (state_q != StRun);
      for (int i = 0; i < LANES; i++) begin
        l_cen_q[i]  <= CEN_OFF;
        l_gwen_q[i] <= GWEN_RD;
        l_wen_q[i]  <= WEN_NONE;
      end
      if (state_q == StLenLo && accept) len_lo_q <= rx_data;
      if (state_q == StLenHi && accept) begin
        n_q    <= len_n[AW:0];
        word_q <= '0;
        lane_q <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        xor_q  <= '0;
`endif
      end
      if (state_q == StData && !fin_q && accept) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_q == LW'(i)) begin
            l_cen_q[i]  <= 1'b0;
            l_gwen_q[i] <= 1'b0;
            l_wen_q[i]  <= WEN_ALL;
            l_a_q[i]    <= word_q;
            l_d_q[i]    <= rx_data;
          end
        end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        xor_q <= xor_q ^ rx_data;
`endif
        if (lane_q == LastLane) begin
          lane_q  <= '0;
          word_q  <= word_q + 1'b1;
          words_q <= words_q + 1'b1;
        end else begin
          lane_q <= lane_q + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    imem_port_mux #(
      .AW(AW)
    ) u_mux (
      .core_sel (run_sel),
      .l_cen    (l_cen_q[g]),
      .l_gwen   (l_gwen_q[g]),
      .l_wen    (l_wen_q[g]),
      .l_a      (l_a_q[g]),
      .l_d      (l_d_q[g]),
      .c_cen    (c_CEN[g]),
      .c_gwen   (c_GWEN[g]),
      .c_wen    (c_WEN[g]),
      .c_a      (c_A[g]),
      .c_d      (c_D[g]),
      .cen      (CEN[g]),
      .gwen     (GWEN[g]),
      .wen      (WEN[g]),
      .a        (A[g]),
      .d        (D[g])
    );
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: scoreboarded SRAM writes plus a shadow imem model.
module tb_imem_boot_loader;

  localparam int LANES = 4;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst, boot_sel, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, core_rst, busy, error;
  logic [AW:0]   words_loaded;
  logic          c_CEN [0:LANES-1], c_GWEN [0:LANES-1];
  logic [7:0]    c_WEN [0:LANES-1], c_D [0:LANES-1];
  logic [AW-1:0] c_A   [0:LANES-1];
  logic          CEN   [0:LANES-1], GWEN [0:LANES-1];
  logic [7:0]    WEN   [0:LANES-1], D [0:LANES-1];
  logic [AW-1:0] A     [0:LANES-1];

  typedef struct {
    int         lane;
    int         addr;
    logic [7:0] data;
  } wr_t;
  typedef logic [7:0] byte_q_t [$];

  wr_t        sb [$];
  logic [7:0] mem [0:LANES-1][0:DEPTH-1];
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;

  imem_boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .boot_sel     (boot_sel),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .core_rst     (core_rst),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded),
    .c_CEN        (c_CEN),
    .c_GWEN       (c_GWEN),
    .c_WEN        (c_WEN),
    .c_A          (c_A),
    .c_D          (c_D),
    .CEN          (CEN),
    .GWEN         (GWEN),
    .WEN          (WEN),
    .A            (A),
    .D            (D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every SRAM write seen on the pins must be the next one the stimulus predicted
  always @(negedge clk) begin
    if (mon_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (CEN[l] === 1'b0 && GWEN[l] === 1'b0) begin
          mem[l][A[l]] = D[l];
          if (sb.size() == 0) begin
            check("unexpected_write", 32'(l), 32'hFFFF);
          end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_lane", 32'(l), 32'(e.lane));
            check("wr_addr", 32'(A[l]), 32'(e.addr));
            check("wr_data", 32'(D[l]), 32'(e.data));
            check("wr_wen", 32'(WEN[l]), 32'h00);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
    for (int l = 0; l < LANES; l++) begin
      check({tag, "_pins"}, {CEN[l], GWEN[l], WEN[l], 7'(A[l]), D[l]}, {1'b1, 1'b1, 8'hFF, 7'd0, 8'h00});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit push, input int idx);
    int t;
    bit ok;
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 50) begin
      if (rx_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        if (push) sb.push_back('{lane: idx % LANES, addr: idx / LANES, data: b});
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (!ok) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_stream(input logic [15:0] n, input byte_q_t data, input int gap_max,
                             input bit bad_chk);
    logic [7:0] x;
    x = 8'h00;
    send_byte(n[7:0], 0, 1'b0, 0);
    send_byte(n[15:8], 0, 1'b0, 0);
    for (int i = 0; i < data.size(); i++) begin
      send_byte(data[i], (gap_max == 0) ? 0 : i % (gap_max + 1), 1'b1, i);
      x = x ^ data[i];
    end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, 0, 1'b0, 0);
`else
    if (bad_chk) x = 8'h00;
`endif
  endtask

  task automatic wait_run(input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (core_rst === 1'b0) ok = 1'b1;
    end
    check({tag, "_reach_run"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t d;
    rst = 1'b1;
    boot_sel = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    for (int l = 0; l < LANES; l++) begin
      c_CEN[l] = 1'b1; c_GWEN[l] = 1'b1; c_WEN[l] = 8'hFF; c_A[l] = '0; c_D[l] = 8'h00;
    end

    // 1: skip load, core drives the SRAM pins
    boot_sel = 1'b0;
    do_reset();
    @(negedge clk);
    check("skip_busy", 32'(busy), 32'd0);
    check("skip_core_rst_t1", 32'(core_rst), 32'd1);
    @(negedge clk);
    check("skip_core_rst_t2", 32'(core_rst), 32'd0);
    check("skip_rx_ready", 32'(rx_ready), 32'd0);
    for (int p = 0; p < 4; p++) begin
      for (int l = 0; l < LANES; l++) begin
        c_CEN[l] = 1'($urandom); c_GWEN[l] = 1'($urandom); c_WEN[l] = 8'($urandom);
        c_A[l] = 9'($urandom); c_D[l] = 8'($urandom);
      end
      #1;
      for (int l = 0; l < LANES; l++) begin
        check("passthru", {CEN[l], GWEN[l], WEN[l], 7'(A[l]), D[l]},
              {c_CEN[l], c_GWEN[l], c_WEN[l], 7'(c_A[l]), c_D[l]});
        check("passthru_a_hi", 32'(A[l][8:7]), 32'(c_A[l][8:7]));
      end
      @(negedge clk);
    end
    for (int l = 0; l < LANES; l++) begin
      c_CEN[l] = 1'b1; c_GWEN[l] = 1'b1; c_WEN[l] = 8'hFF; c_A[l] = '0; c_D[l] = 8'h00;
    end

    // 2: two-word image
    mon_en = 1'b1;
    boot_sel = 1'b1;
    do_reset();
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_stream(16'd2, d, 0, 1'b0);
    wait_run("load2");
    check("load2_words", 32'(words_loaded), 32'd2);
    check("load2_error", 32'(error), 32'd0);
    check("load2_busy", 32'(busy), 32'd0);
    check("load2_mem00", 32'(mem[0][0]), 32'h13);
    check("load2_mem01", 32'(mem[0][1]), 32'h6F);
    check("load2_mem10", 32'(mem[1][0]), 32'h00);
    check("load2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: illegal lengths 0 and 513
    for (int k = 0; k < 2; k++) begin
      logic [15:0] n;
      n = (k == 0) ? 16'd0 : 16'd513;
      do_reset();
      send_byte(n[7:0], 0, 1'b0, 0);
      send_byte(n[15:8], 0, 1'b0, 0);
      check("badlen_error", 32'(error), 32'd1);
      check("badlen_core_rst", 32'(core_rst), 32'd1);
      check("badlen_rx_ready", 32'(rx_ready), 32'd0);
      check("badlen_busy", 32'(busy), 32'd0);
      rx_valid = 1'b1;
      rx_data = 8'hAA;
      repeat (5) @(negedge clk);
      rx_valid = 1'b0;
      check("badlen_sticky", 32'(error), 32'd1);
      check("badlen_core_rst_hold", 32'(core_rst), 32'd1);
      check("badlen_words", 32'(words_loaded), 32'd0);
    end

    // 4: same image back-to-back and with 0..5 cycle gaps
    d = {};
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 12; i++) mem[i % LANES][i / LANES] = 8'hxx;
      do_reset();
      send_stream(16'd3, d, (g == 0) ? 0 : 5, 1'b0);
      wait_run("gap");
      check("gap_words", 32'(words_loaded), 32'd3);
      for (int i = 0; i < 12; i++) check("gap_mem", 32'(mem[i % LANES][i / LANES]), 32'(d[i]));
    end

    // 5: reset during word 3, then reload
    do_reset();
    send_byte(8'd8, 0, 1'b0, 0);
    send_byte(8'd0, 0, 1'b0, 0);
    for (int i = 0; i < 13; i++) send_byte(8'h80 + 8'(i), 0, 1'b1, i);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    check("midrst_partial", 32'(mem[0][3]), 32'h8C);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    send_stream(16'd2, d, 0, 1'b0);
    wait_run("reload");
    check("reload_words", 32'(words_loaded), 32'd2);
    check("reload_mem31", 32'(mem[3][1]), 32'hB4);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    // 6: checksum good then bad
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    send_stream(16'd1, d, 0, 1'b0);
    wait_run("chk_good");
    check("chk_good_error", 32'(error), 32'd0);
    do_reset();
    send_stream(16'd1, d, 0, 1'b1);
    check("chk_bad_error", 32'(error), 32'd1);
    check("chk_bad_core_rst", 32'(core_rst), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
